// File: rtl/inv_bvashr_pkg.sv
// Shared types for the inverse arithmetic-shift solver: FSM states and mode encodings.
package inv_bvashr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic MODE_X_SHIFTED = 1'b0;  // solve x >>> s == t
    localparam logic MODE_X_AMOUNT  = 1'b1;  // solve s >>> x == t

endpackage

// File: rtl/inv_bvashr_solver_if.sv
// Request/result handshake bundle for the solver; master = requester, slave = solver.
interface inv_bvashr_solver_if #(parameter int W = 4);
    logic         start_valid;
    logic         start_ready;
    logic         mode;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] x;
    logic         found;

    modport master (
        output start_valid, mode, s, t, res_ready,
        input  start_ready, res_valid, x, found
    );

    modport slave (
        input  start_valid, mode, s, t, res_ready,
        output start_ready, res_valid, x, found
    );
endinterface

// File: rtl/inv_bvashr_shift.sv
// Combinational arithmetic right shift; amounts >= W saturate to W copies of the MSB.
module inv_bvashr_shift #(
    parameter int W = 4
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] amount,
    output logic [W-1:0] shifted
);
    always_comb begin
        if (32'(amount) >= W) shifted = {W{value[W-1]}};
        else                  shifted = $signed(value) >>> amount;
    end
endmodule

// File: rtl/inv_bvashr_solver.sv
// Inverse solver for arithmetic right shift: finds the shifted value (mode 0, one cycle)
// or the smallest shift amount (mode 1, linear search k = 0..W).
import inv_bvashr_pkg::*;

module inv_bvashr_solver #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_bvashr_solver_if.slave   bus
);
    localparam int KW = $clog2(W + 1);

    state_t        state;
    logic          mode_q;
    logic [W-1:0]  s_q, t_q;
    logic [KW-1:0] k;
    logic [W-1:0]  x_q;
    logic          found_q;

    logic [W-1:0]  xcand, sh_val, sh_amt, sh_out;
    logic          hit, last;

    // Mode 0 reuses the shifter as a round-trip check: the candidate t << s solves the
    // equation exactly when shifting it back reproduces t (also covers s >= W).
    always_comb begin
        xcand = (32'(s_q) >= W) ? {W{t_q[W-1]}} : (t_q << s_q);
        if (mode_q == MODE_X_SHIFTED) begin
            sh_val = xcand;
            sh_amt = s_q;
        end else begin
            sh_val = s_q;
            sh_amt = W'(k);
        end
        hit  = (sh_out == t_q);
        last = (32'(k) == W);
    end

    inv_bvashr_shift #(.W(W)) u_shift (
        .value   (sh_val),
        .amount  (sh_amt),
        .shifted (sh_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            s_q     <= '0;
            t_q     <= '0;
            k       <= '0;
            x_q     <= '0;
            found_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        mode_q <= bus.mode;
                        s_q    <= bus.s;
                        t_q    <= bus.t;
                        k      <= '0;
                        state  <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (mode_q == MODE_X_SHIFTED) begin
                        x_q     <= hit ? xcand : '0;
                        found_q <= hit;
                        state   <= DONE;
                    end else if (hit) begin
                        x_q     <= W'(k);
                        found_q <= 1'b1;
                        state   <= DONE;
                    end else if (last) begin
                        x_q     <= '0;
                        found_q <= 1'b0;
                        state   <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        x_q     <= '0;
                        found_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign bus.x           = x_q;
    assign bus.found       = found_q;
endmodule

// File: doc/inv_bvashr_solver.md
INV_BVASHR_SOLVER -- requirements
Module: inv_bvashr_solver

Interface
REQ-001 Parameter: W, default 4, operand/result bit width; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: start_valid  input  1  request present.
REQ-005 Port: start_ready  output  1  solver can accept a request.
REQ-006 Port: mode  input  1  0 = solve x >>> s == t for x; 1 = solve s >>> x == t for x.
REQ-007 Port: s  input  W  known operand, two's complement.
REQ-008 Port: t  input  W  target value.
REQ-009 Port: res_valid  output  1  result present.
REQ-010 Port: res_ready  input  1  consumer takes result.
REQ-011 Port: x  output  W  solution.
REQ-012 Port: found  output  1  1 = x is a valid solution; 0 = no solution exists, x = 0.

Function
REQ-013 The block SHALL implement FSM states IDLE, SEARCH, DONE.
REQ-014 start_ready SHALL be 1 exactly in IDLE; res_valid SHALL be 1 exactly in DONE.
REQ-015 On an edge with start_valid=1 in IDLE (acceptance edge E0), the block SHALL latch mode, s, t, clear candidate counter k to 0 and enter SEARCH.
REQ-016 Inputs mode, s, t, start_valid SHALL be ignored outside IDLE.
REQ-017 ">>>" SHALL mean arithmetic right shift with sign fill; any shift amount >= W SHALL yield W copies of the operand MSB.
REQ-018 Mode 0: a solution SHALL be reported iff the top min(s,W-1)+1 bits of t are all equal (s unsigned); x SHALL be t << s when s < W, else W copies of t[W-1].
REQ-019 Mode 0 SHALL complete in one SEARCH cycle: DONE entered, res_valid high, after edge E1.
REQ-020 Mode 1: the block SHALL evaluate one candidate per cycle, k = 0,1,...,W; candidate k is compared in the cycle following edge Ek.
REQ-021 Mode 1 SHALL stop at the first (smallest) k with s >>> k == t and enter DONE with x = k, found = 1, at edge Ek+1.
REQ-022 Mode 1: if candidate k = W fails, the block SHALL enter DONE at edge EW+1 with x = 0, found = 0.
REQ-023 The counter k SHALL be ceil(log2(W+1)) bits wide and SHALL NOT wrap; k = W is the terminal candidate.
REQ-024 In DONE, x and found SHALL remain stable until an edge with res_ready=1, after which the FSM SHALL return to IDLE (start_ready high the following cycle; no same-edge re-acceptance).
REQ-025 x and found SHALL be registered outputs; outside DONE they SHALL hold 0.

Reset
REQ-026 When rst_n=0, the block SHALL immediately force state IDLE, k = 0, latched operands 0, x = 0, found = 0, res_valid = 0; start_ready SHALL be 1 once reset has deasserted.
REQ-027 Reset asserted during SEARCH or DONE SHALL abort the request with no result delivered.

Structure
REQ-028 A shared package inv_bvashr_pkg SHALL hold the FSM state enum and the mode encodings (MODE_X_SHIFTED = 0, MODE_X_AMOUNT = 1).
REQ-029 Sign-filling shift SHALL be a combinational sub-module inv_bvashr_shift (parameter W; inputs value, amount; output shifted), instantiated once and shared by both modes.

Verification (W=4)
REQ-030 mode=1, s=4'b1000, t=4'b1110 -> x=2, found=1, res_valid high after E3.
REQ-031 mode=1, s=4'b0110, t=4'b0101 -> x=0, found=0, res_valid high after E5; mode=1, s=0, t=0 -> x=0, found=1 after E1.
REQ-032 mode=0, s=2, t=4'b1110 -> x=4'b1000, found=1 after E1; mode=0, s=1, t=4'b0100 -> x=0, found=0; mode=0, s=9, t=4'b1111 -> x=4'b1111, found=1.
REQ-033 Backpressure: hold res_ready=0 for 5 cycles in DONE while toggling start_valid, s, t -> x/found stable, start_ready=0, no new request accepted; res_ready=1 -> IDLE next edge.
REQ-034 Assert rst_n=0 mid-SEARCH (mode=1, k=2) -> res_valid, x, found 0 immediately, start_ready=1 after release, subsequent request solved correctly.
REQ-035 Exhaustive random: all s, t, mode for W=4 compared against a reference model, including minimality of x in mode 1.
